// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: an I-cache (read-only) and a D-cache share one pipelined memory.
// Round-robin ownership, bounded outstanding reads, in-order read return routed to the last owner.
module mem_arbiter #(
    parameter int unsigned MAX_OUT = 4
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        i_req,
    input  logic [15:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [15:0] i_rdata,

    input  logic        d_req,
    input  logic        d_wr,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [15:0] d_rdata,

    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_valid
);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StGrantI = 2'd1,
        StGrantD = 2'd2,
        StDrain  = 2'd3
    } state_e;

    localparam logic [2:0] MaxOutCnt = 3'(MAX_OUT);
    localparam logic       OwnerI    = 1'b0;
    localparam logic       OwnerD    = 1'b1;

    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       last_owner_q, last_owner_d;

    logic full;
    logic rd_issue;
    logic rd_return;

    // Grants are decoded from the registered state; a return in the same cycle frees a slot.
    always_comb begin
        full      = (cnt_q == MaxOutCnt) && !mem_valid;
        i_gnt     = (state_q == StGrantI) && i_req && !full;
        d_gnt     = (state_q == StGrantD) && d_req && !full;

        mem_en    = i_gnt | d_gnt;
        mem_wr    = d_gnt & d_wr;
        mem_addr  = 16'h0000;
        if (i_gnt) begin
            mem_addr = i_addr;
        end else if (d_gnt) begin
            mem_addr = d_addr;
        end
        mem_wdata = d_gnt ? d_wdata : 16'h0000;

        rd_issue  = mem_en & ~mem_wr;
        rd_return = mem_valid && (cnt_q != 3'd0);

        i_rvalid  = rd_return && (last_owner_q == OwnerI);
        d_rvalid  = rd_return && (last_owner_q == OwnerD);
        i_rdata   = mem_rdata;
        d_rdata   = mem_rdata;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (rd_issue && !rd_return) begin
            cnt_d = cnt_q + 3'd1;
        end else if (!rd_issue && rd_return) begin
            cnt_d = cnt_q - 3'd1;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        case (state_q)
            StIdle: begin
                if (i_req && d_req) begin
                    if (last_owner_q == OwnerI) begin
                        state_d      = StGrantD;
                        last_owner_d = OwnerD;
                    end else begin
                        state_d      = StGrantI;
                        last_owner_d = OwnerI;
                    end
                end else if (i_req) begin
                    state_d      = StGrantI;
                    last_owner_d = OwnerI;
                end else if (d_req) begin
                    state_d      = StGrantD;
                    last_owner_d = OwnerD;
                end
            end
            StGrantI: begin
                if (!i_req) begin
                    state_d = (cnt_d != 3'd0) ? StDrain : StIdle;
                end
            end
            StGrantD: begin
                if (!d_req) begin
                    state_d = (cnt_d != 3'd0) ? StDrain : StIdle;
                end
            end
            StDrain: begin
                if (cnt_q == 3'd0) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cnt_q        <= 3'd0;
            last_owner_q <= OwnerI;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_owner_q <= last_owner_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: latency-programmable memory model, in-order read scoreboard,
// and one task per scenario.
module tb_mem_arbiter;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_GRANTI = 2'd1;
    localparam logic [1:0] S_GRANTD = 2'd2;
    localparam logic [1:0] S_DRAIN  = 2'd3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req, d_req, d_wr;
    logic [15:0] i_addr, d_addr, d_wdata;
    logic        i_gnt, i_rvalid, d_gnt, d_rvalid;
    logic [15:0] i_rdata, d_rdata;
    logic        mem_en, mem_wr;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_valid;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int mem_lat = 4;
    int d_rv_seen = 0;

    typedef struct {
        int          due;
        logic [15:0] data;
    } mrec_t;
    typedef struct {
        logic        owner;
        logic [15:0] data;
    } sbrec_t;

    mrec_t  mq[$];
    sbrec_t sb[$];

    mem_arbiter #(.MAX_OUT(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_gnt    (i_gnt),
        .i_rvalid (i_rvalid),
        .i_rdata  (i_rdata),
        .d_req    (d_req),
        .d_wr     (d_wr),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
        .mem_en   (mem_en),
        .mem_wr   (mem_wr),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_valid(mem_valid)
    );

    always #5 clk = ~clk;

    // Memory: a read issued in cycle k returns ~addr in cycle k+mem_lat, in order.
    // Pending reads survive a DUT reset so late returns can be observed.
    initial begin
        mem_valid = 1'b0;
        mem_rdata = 16'h0000;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (mq.size() > 0 && mq[0].due <= cyc) begin
                mem_valid = 1'b1;
                mem_rdata = mq[0].data;
                void'(mq.pop_front());
            end else begin
                mem_valid = 1'b0;
                mem_rdata = 16'h0000;
            end
            @(negedge clk);
            if (mem_en && !mem_wr) mq.push_back('{due: cyc + mem_lat, data: ~mem_addr});
        end
    end

    // Scoreboard: expected reads pushed from requester inputs at grant, popped on return.
    always @(negedge clk) begin
        logic exp_i, exp_d;
        if (!rst_n) begin
            sb.delete();
        end else begin
            checks++;
            if (dut.cnt_q !== 3'(sb.size())) begin
                errors++;
                $display("FAIL cnt: got %0d expected %0d", dut.cnt_q, sb.size());
            end
            checks++;
            if (mem_en !== (i_gnt | d_gnt) || (i_gnt && d_gnt)) begin
                errors++;
                $display("FAIL gnt_en: mem_en=%b i_gnt=%b d_gnt=%b", mem_en, i_gnt, d_gnt);
            end
            if (!mem_en) begin
                checks++;
                if ({mem_wr, mem_addr, mem_wdata} !== 33'd0) begin
                    errors++;
                    $display("FAIL idle_bus: wr=%b addr=%h wdata=%h expected all 0",
                             mem_wr, mem_addr, mem_wdata);
                end
            end
            checks++;
            if (i_rdata !== mem_rdata || d_rdata !== mem_rdata) begin
                errors++;
                $display("FAIL rdata_pass: i=%h d=%h expected %h", i_rdata, d_rdata, mem_rdata);
            end
            exp_i = mem_valid && sb.size() > 0 && sb[0].owner == 1'b0;
            exp_d = mem_valid && sb.size() > 0 && sb[0].owner == 1'b1;
            checks++;
            if ({i_rvalid, d_rvalid} !== {exp_i, exp_d}) begin
                errors++;
                $display("FAIL rvalid: got i=%b d=%b expected i=%b d=%b",
                         i_rvalid, d_rvalid, exp_i, exp_d);
            end
            if (mem_valid && sb.size() > 0) begin
                checks++;
                if ((sb[0].owner ? d_rdata : i_rdata) !== sb[0].data) begin
                    errors++;
                    $display("FAIL rdata_order: got %h expected %h",
                             sb[0].owner ? d_rdata : i_rdata, sb[0].data);
                end
                void'(sb.pop_front());
            end
            if (d_rvalid) d_rv_seen++;
            if (i_gnt) sb.push_back('{owner: 1'b0, data: ~i_addr});
            else if (d_gnt && !d_wr) sb.push_back('{owner: 1'b1, data: ~d_addr});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input logic [1:0] st, input int lim, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < lim; k++) begin
            @(negedge clk);
            if (dut.state_q == st) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0;
        i_addr = 16'h0; d_addr = 16'h0; d_wdata = 16'h0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({dut.state_q, dut.cnt_q, dut.last_owner_q} !== {S_IDLE, 3'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: state=%0d cnt=%0d owner=%b expected 0 0 0",
                     dut.state_q, dut.cnt_q, dut.last_owner_q);
        end
        checks++;
        if ({i_gnt, d_gnt, i_rvalid, d_rvalid, mem_en, mem_wr, mem_addr, mem_wdata} !== 38'd0)
        begin
            errors++;
            $display("FAIL reset_outputs: gnt=%b%b rv=%b%b en=%b wr=%b addr=%h wd=%h expected 0",
                     i_gnt, d_gnt, i_rvalid, d_rvalid, mem_en, mem_wr, mem_addr, mem_wdata);
        end
    endtask

    task automatic test_round_robin();
        bit ok, got, saw_drain;
        mem_lat = 4;
        tick();
        i_req = 1'b1; d_req = 1'b1; d_wr = 1'b0;
        i_addr = 16'h0100; d_addr = 16'h0200;
        @(negedge clk);
        checks++;
        if ({i_gnt, d_gnt} !== 2'b00) begin
            errors++;
            $display("FAIL rr_latency: gnt i=%b d=%b expected 00", i_gnt, d_gnt);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({i_gnt, d_gnt} !== 2'b01) begin
            errors++;
            $display("FAIL rr_first_d: gnt i=%b d=%b expected i=0 d=1", i_gnt, d_gnt);
        end
        for (int k = 0; k < 2; k++) begin
            tick();
            d_addr = d_addr + 16'd2;
            @(negedge clk);
            checks++;
            if ({i_gnt, d_gnt} !== 2'b01) begin
                errors++;
                $display("FAIL rr_d_hold: gnt i=%b d=%b expected i=0 d=1", i_gnt, d_gnt);
            end
        end
        tick();
        d_req = 1'b0;
        got = 1'b0; saw_drain = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (dut.state_q == S_DRAIN) saw_drain = 1'b1;
            if (i_gnt) begin
                got = 1'b1;
                break;
            end
        end
        checks++;
        if (!(got && saw_drain)) begin
            errors++;
            $display("FAIL rr_i_after_drain: i_gnt=%b drain_seen=%b expected 1 1", got, saw_drain);
        end
        // D asks while I still owns: must not be granted.
        tick();
        d_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            i_addr = i_addr + 16'd2;
            @(negedge clk);
            checks++;
            if ({i_gnt, d_gnt} !== 2'b10) begin
                errors++;
                $display("FAIL rr_no_preempt: gnt i=%b d=%b expected i=1 d=0", i_gnt, d_gnt);
            end
            tick();
        end
        i_req = 1'b0; d_req = 1'b0;
        wait_state(S_IDLE, 30, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rr_idle1: state=%0d expected %0d", dut.state_q, S_IDLE);
        end
        tick();
        i_req = 1'b1; d_req = 1'b1; d_addr = 16'h0220;
        tick();
        @(negedge clk);
        checks++;
        if ({i_gnt, d_gnt} !== 2'b01) begin
            errors++;
            $display("FAIL rr_second_d: gnt i=%b d=%b expected i=0 d=1", i_gnt, d_gnt);
        end
        tick();
        i_req = 1'b0; d_req = 1'b0;
        wait_state(S_IDLE, 30, ok);
        tick();
        i_req = 1'b1; d_req = 1'b1; i_addr = 16'h0180;
        tick();
        @(negedge clk);
        checks++;
        if ({i_gnt, d_gnt} !== 2'b10) begin
            errors++;
            $display("FAIL rr_third_i: gnt i=%b d=%b expected i=1 d=0", i_gnt, d_gnt);
        end
        tick();
        i_req = 1'b0; d_req = 1'b0;
        wait_state(S_IDLE, 30, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rr_idle2: state=%0d expected %0d", dut.state_q, S_IDLE);
        end
    endtask

    task automatic test_d_burst();
        int issues, first, peak, rv0;
        bit saw_drain, ok;
        issues = 0; first = -1; peak = 0; saw_drain = 1'b0; ok = 1'b0;
        mem_lat = 4;
        rv0 = d_rv_seen;
        tick();
        d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0010;
        for (int c = 0; c < 60 && issues < 8; c++) begin
            @(negedge clk);
            if (int'(dut.cnt_q) > peak) peak = int'(dut.cnt_q);
            if (d_gnt) begin
                if (first < 0) first = c;
                issues++;
                checks++;
                if (mem_addr !== d_addr || mem_wr !== 1'b0) begin
                    errors++;
                    $display("FAIL burst_bus: addr=%h wr=%b expected %h 0", mem_addr, mem_wr, d_addr);
                end
            end
            tick();
            if (issues == 8) d_req = 1'b0;
            else d_addr = 16'h0010 + 16'(2 * issues);
        end
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (int'(dut.cnt_q) > peak) peak = int'(dut.cnt_q);
            if (dut.state_q == S_DRAIN) saw_drain = 1'b1;
            if (dut.state_q == S_IDLE) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (first !== 1 || issues !== 8) begin
            errors++;
            $display("FAIL burst_issue: first=%0d issues=%0d expected 1 8", first, issues);
        end
        checks++;
        if (peak !== 4) begin
            errors++;
            $display("FAIL burst_peak: got %0d expected 4", peak);
        end
        checks++;
        if (d_rv_seen - rv0 !== 8) begin
            errors++;
            $display("FAIL burst_rvalid: got %0d expected 8", d_rv_seen - rv0);
        end
        checks++;
        if (!(ok && saw_drain)) begin
            errors++;
            $display("FAIL burst_drain: idle=%b drain_seen=%b expected 1 1", ok, saw_drain);
        end
    endtask

    task automatic test_write();
        tick();
        d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0040; d_wdata = 16'hBEEF;
        @(negedge clk);
        checks++;
        if (mem_en !== 1'b0) begin
            errors++;
            $display("FAIL wr_latency: mem_en=%b expected 0", mem_en);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({d_gnt, mem_en, mem_wr, mem_addr, mem_wdata} !== {3'b111, 16'h0040, 16'hBEEF}) begin
            errors++;
            $display("FAIL wr_bus: gnt=%b en=%b wr=%b addr=%h wd=%h expected 1 1 1 0040 BEEF",
                     d_gnt, mem_en, mem_wr, mem_addr, mem_wdata);
        end
        tick();
        d_req = 1'b0; d_wr = 1'b0;
        @(negedge clk);
        checks++;
        if ({mem_en, dut.cnt_q, dut.state_q} !== {1'b0, 3'd0, S_GRANTD}) begin
            errors++;
            $display("FAIL wr_release: en=%b cnt=%0d state=%0d expected 0 0 %0d",
                     mem_en, dut.cnt_q, dut.state_q, S_GRANTD);
        end
        tick();
        @(negedge clk);
        checks++;
        if (dut.state_q !== S_IDLE) begin
            errors++;
            $display("FAIL wr_idle: state=%0d expected %0d", dut.state_q, S_IDLE);
        end
    endtask

    task automatic test_i_stall();
        bit exp_gnt [8];
        bit ok;
        exp_gnt = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        mem_lat = 6;
        tick();
        i_req = 1'b1; i_addr = 16'h0300;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            checks++;
            if (i_gnt !== exp_gnt[c]) begin
                errors++;
                $display("FAIL stall_gnt c%0d: got %b expected %b", c, i_gnt, exp_gnt[c]);
            end
            if (c == 7) begin
                checks++;
                if (!(i_gnt && mem_valid)) begin
                    errors++;
                    $display("FAIL stall_resume: i_gnt=%b mem_valid=%b expected 1 1",
                             i_gnt, mem_valid);
                end
            end
            tick();
            if (i_gnt) i_addr = i_addr + 16'd2;
        end
        i_req = 1'b0;
        wait_state(S_IDLE, 40, ok);
        checks++;
        if (!ok || sb.size() != 0) begin
            errors++;
            $display("FAIL stall_idle: idle=%b pending=%0d expected 1 0", ok, sb.size());
        end
    endtask

    task automatic test_stray_valid();
        @(negedge clk);
        mq.push_back('{due: cyc + 1, data: 16'hDEAD});
        @(negedge clk);
        checks++;
        if ({i_rvalid, d_rvalid} !== 2'b00) begin
            errors++;
            $display("FAIL stray_rvalid: i=%b d=%b expected 0 0", i_rvalid, d_rvalid);
        end
        @(negedge clk);
        checks++;
        if ({dut.cnt_q, dut.state_q} !== {3'd0, S_IDLE}) begin
            errors++;
            $display("FAIL stray_cnt: cnt=%0d state=%0d expected 0 0", dut.cnt_q, dut.state_q);
        end
    endtask

    task automatic test_reset_mid();
        int issues;
        issues = 0;
        mem_lat = 8;
        tick();
        i_req = 1'b1; i_addr = 16'h0500;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (i_gnt) issues++;
            if (issues == 3) break;
            tick();
            if (i_gnt) i_addr = i_addr + 16'd2;
        end
        tick();
        i_req = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({dut.state_q, dut.cnt_q} !== {S_GRANTI, 3'd3}) begin
            errors++;
            $display("FAIL rstmid_pre: state=%0d cnt=%0d expected %0d 3",
                     dut.state_q, dut.cnt_q, S_GRANTI);
        end
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({dut.state_q, dut.cnt_q, mem_en, i_gnt, d_gnt} !== {S_IDLE, 3'd0, 3'b000}) begin
            errors++;
            $display("FAIL rstmid_state: state=%0d cnt=%0d en=%b expected 0 0 0",
                     dut.state_q, dut.cnt_q, mem_en);
        end
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (mem_valid) begin
                checks++;
                if ({i_rvalid, d_rvalid} !== 2'b00) begin
                    errors++;
                    $display("FAIL rstmid_late: i=%b d=%b expected 0 0", i_rvalid, d_rvalid);
                end
            end
        end
        checks++;
        if ({dut.state_q, dut.cnt_q} !== {S_IDLE, 3'd0}) begin
            errors++;
            $display("FAIL rstmid_end: state=%0d cnt=%0d expected 0 0", dut.state_q, dut.cnt_q);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_d_burst();
        test_write();
        test_i_stall();
        test_stray_valid();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: MAX_OUT, 4, maximum outstanding memory reads; legal range 1..7.
REQ-002 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  in  1  reset, synchronous, active-low.
REQ-004 Port: i_req  in  1  I-cache requests the memory (read-only requester).
REQ-005 Port: i_addr  in  16  I-cache read address.
REQ-006 Port: i_gnt  out  1  I-cache access issued to memory this cycle.
REQ-007 Port: i_rvalid  out  1  read data valid for the I-cache.
REQ-008 Port: i_rdata  out  16  read data to the I-cache.
REQ-009 Port: d_req  in  1  D-cache requests the memory.
REQ-010 Port: d_wr  in  1  D-cache access is a write (1) or read (0).
REQ-011 Port: d_addr  in  16  D-cache address.
REQ-012 Port: d_wdata  in  16  D-cache write data.
REQ-013 Port: d_gnt  out  1  D-cache access issued to memory this cycle.
REQ-014 Port: d_rvalid  out  1  read data valid for the D-cache.
REQ-015 Port: d_rdata  out  16  read data to the D-cache.
REQ-016 Port: mem_en  out  1  memory access enable.
REQ-017 Port: mem_wr  out  1  memory write enable.
REQ-018 Port: mem_addr  out  16  memory address.
REQ-019 Port: mem_wdata  out  16  memory write data.
REQ-020 Port: mem_rdata  in  16  memory read data.
REQ-021 Port: mem_valid  in  1  memory read data valid, returned in issue order.

Function
REQ-022 States SHALL be IDLE, GRANT_I, GRANT_D, DRAIN; state, a 3-bit outstanding counter cnt, and a last_owner bit SHALL be registered.
REQ-023 IDLE: only i_req -> GRANT_I; only d_req -> GRANT_D; both -> grant the requester != last_owner; neither -> stay; on entering GRANT_X, last_owner SHALL be set to X.
REQ-024 Arbitration latency SHALL be one cycle: a request seen in IDLE issues at the earliest in the following cycle.
REQ-025 In GRANT_X: x_gnt = x_req & ~(cnt==MAX_OUT & ~mem_valid); the other requester's gnt SHALL be 0.
REQ-026 mem_en SHALL equal i_gnt | d_gnt; mem_addr/mem_wdata SHALL be driven from the owner (mem_wdata = d_wdata for D, 0 for I); mem_wr = d_gnt & d_wr.
REQ-027 When mem_en=0, mem_wr, mem_addr and mem_wdata SHALL be 0.
REQ-028 cnt SHALL increment on an issued read, decrement on mem_valid, hold when both occur together; writes SHALL NOT change cnt.
REQ-029 mem_valid with cnt==0 SHALL be ignored: cnt stays 0, no rvalid asserted (no underflow).
REQ-030 x_rvalid = mem_valid & (cnt!=0) & (last_owner==X); both rdata outputs SHALL equal mem_rdata at all times.
REQ-031 GRANT_X with x_req low: next-cycle cnt != 0 -> DRAIN; else -> IDLE.
REQ-032 DRAIN: no gnt issued; -> IDLE in the cycle after cnt reaches 0; requests arriving during DRAIN wait.
REQ-033 Ownership SHALL persist while the owner holds req; the other requester SHALL not be granted until the owner releases and drains (no preemption).
REQ-034 Round-robin SHALL guarantee that, under continuous contention, grants alternate I, D, I, ... per ownership period.

Reset
REQ-035 With rst_n=0 at a rising edge: state=IDLE, cnt=0, last_owner=I; all outputs except rdata SHALL be 0 in the following cycle.
REQ-036 Reset mid-operation SHALL abandon outstanding reads; late mem_valid after reset SHALL be ignored per REQ-029.

Verification
REQ-037 d_req=1, d_wr=0, d_addr=0x0010..0x001E held 8 issues, memory latency 4 -> d_gnt first in cycle 2, cnt peaks at 4, 8 d_rvalid pulses, then DRAIN -> IDLE.
REQ-038 i_req and d_req rise together from reset -> D granted first (last_owner=I); after D releases and drains, I granted; next contention -> D.
REQ-039 d_req, d_wr=1, d_addr=0x0040, d_wdata=0xBEEF -> one cycle mem_en=1, mem_wr=1, mem_addr=0x0040, mem_wdata=0xBEEF, cnt stays 0, GRANT_D -> IDLE on release.
REQ-040 MAX_OUT=4 with memory stalled 6 cycles -> exactly 4 issues then i_gnt=0; issue resumes in the same cycle as the first mem_valid.
REQ-041 rst_n=0 asserted with cnt=3 in GRANT_I, then mem_valid pulses -> state IDLE, cnt 0, i_rvalid and d_rvalid remain 0.
REQ-042 mem_valid pulse while IDLE and cnt=0 -> no rvalid, cnt remains 0.
